// File: rtl/mac_lookup_req_gen_pkg.sv
// Shared encodings and header field positions for the MAC lookup request generator.
package mac_lookup_req_gen_pkg;

  // Packet parser progress through the module header(s) and first two data words.
  typedef enum logic [1:0] {
    MODULE_HDRS = 2'd0,
    WORD1       = 2'd1,
    WORD2       = 2'd2,
    WAIT_EOP    = 2'd3
  } parser_state_t;

  // Four-phase handshake with the MAC lookup table.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_ACK     = 2'd1,
    WAIT_ACK_LOW = 2'd2
  } lookup_state_t;

  // ctrl value that tags the IOQ module header word.
  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;

  // Header field offsets within a 64-bit stream word.
  localparam int SRC_PORT_POS  = 16;  // src_port LSB inside the IOQ header
  localparam int DST_MAC_HI    = 63;  // dst_mac MSB inside data word 1
  localparam int SRC_MAC_SPLIT = 16;  // bits of src_mac carried by data word 1
  localparam int MAC_W         = 48;

endpackage

// File: rtl/small_fifo_fwft.sv
// Small first-word-fall-through FIFO; head drives 0 while empty.
module small_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count
);

  localparam int                    DEPTH     = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_reg;
  logic [DEPTH_BITS-1:0] rd_ptr_reg;
  logic [DEPTH_BITS:0]   count_reg;
  logic                  do_rd;
  logic                  do_wr;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);
  assign count = count_reg;
  // Pops on empty are ignored; a push on full only lands when a legal pop frees the slot.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign dout  = empty ? '0 : mem_reg[rd_ptr_reg];

  // Storage write; no reset needed since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mac_lookup_req_gen.sv
// Snoops the packet stream for src_port/dst_mac/src_mac, queues one lookup per
// packet, runs the LUT handshake and queues each returned dst_ports vector.
module mac_lookup_req_gen #(
  parameter int                    DATA_WIDTH         = 64,
  parameter int                    CTRL_WIDTH         = 8,
  parameter int                    NUM_OUTPUT_QUEUES  = 8,
  parameter int                    NUM_IQ_BITS        = 3,
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = mac_lookup_req_gen_pkg::IO_QUEUE_STAGE_NUM,
  parameter int                    FIFO_DEPTH_BITS    = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [47:0]                  dst_mac,
  output logic [47:0]                  src_mac,
  output logic [NUM_IQ_BITS-1:0]       src_port,
  output logic                         lookup_req,
  input  logic                         lookup_ack,
  input  logic [NUM_OUTPUT_QUEUES-1:0] lut_dst_ports,
  output logic [NUM_OUTPUT_QUEUES-1:0] res_dst_ports,
  output logic                         res_empty,
  input  logic                         res_rd_en,
  output logic                         parse_err
);

  import mac_lookup_req_gen_pkg::*;

  // Request entry layout: {src_port, src_mac, dst_mac}.
  localparam int REQ_W = 2 * MAC_W + NUM_IQ_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] REQ_RDY_MAX =
    (FIFO_DEPTH_BITS + 1)'((1 << FIFO_DEPTH_BITS) - 2);

  parser_state_t                p_state_reg, p_state_next;
  lookup_state_t                l_state_reg, l_state_next;
  logic [NUM_IQ_BITS-1:0]       src_port_reg, src_port_next;
  logic [MAC_W-1:0]             dst_mac_reg, dst_mac_next;
  logic [SRC_MAC_SPLIT-1:0]     src_mac_hi_reg, src_mac_hi_next;
  logic                         parse_err_reg, parse_err_next;

  logic                         req_push, req_pop, req_empty, req_full_unused;
  logic [REQ_W-1:0]             req_din, req_dout;
  logic [FIFO_DEPTH_BITS:0]     req_count;
  logic                         res_push, res_full;
  logic [FIFO_DEPTH_BITS:0]     res_count_unused;

  // Parser: pick header fields out of the stream and push a request on word 2.
  always_comb begin
    p_state_next    = p_state_reg;
    src_port_next   = src_port_reg;
    dst_mac_next    = dst_mac_reg;
    src_mac_hi_next = src_mac_hi_reg;
    parse_err_next  = 1'b0;
    req_push        = 1'b0;
    if (in_wr) begin
      case (p_state_reg)
        MODULE_HDRS: begin
          if (in_ctrl == IO_QUEUE_STAGE_NUM) begin
            src_port_next = in_data[SRC_PORT_POS +: NUM_IQ_BITS];
          end else if (in_ctrl == '0) begin
            dst_mac_next    = in_data[DST_MAC_HI -: MAC_W];
            src_mac_hi_next = in_data[SRC_MAC_SPLIT-1:0];
            p_state_next    = WORD2;
          end
        end
        WORD2: begin
          // src_port is cleared so a following packet without IOQ header gets port 0.
          src_port_next = '0;
          if (in_ctrl == '0) begin
            req_push     = 1'b1;
            p_state_next = WAIT_EOP;
          end else begin
            parse_err_next = 1'b1;
            p_state_next   = MODULE_HDRS;
          end
        end
        WAIT_EOP: begin
          if (in_ctrl != '0) p_state_next = MODULE_HDRS;
        end
        default: p_state_next = MODULE_HDRS;
      endcase
    end
  end

  // Parser state and captured header fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state_reg    <= MODULE_HDRS;
      src_port_reg   <= '0;
      dst_mac_reg    <= '0;
      src_mac_hi_reg <= '0;
      parse_err_reg  <= 1'b0;
    end else begin
      p_state_reg    <= p_state_next;
      src_port_reg   <= src_port_next;
      dst_mac_reg    <= dst_mac_next;
      src_mac_hi_reg <= src_mac_hi_next;
      parse_err_reg  <= parse_err_next;
    end
  end

  assign req_din   = {src_port_reg, src_mac_hi_reg, in_data[63:32], dst_mac_reg};
  assign parse_err = parse_err_reg;
  // One slot of margin: the packet already in flight can always complete its push.
  assign in_rdy    = (req_count <= REQ_RDY_MAX);

  small_fifo_fwft #(
    .WIDTH      (REQ_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (req_din),
    .wr_en   (req_push),
    .rd_en   (req_pop),
    .dout    (req_dout),
    .full    (req_full_unused),
    .empty   (req_empty),
    .count   (req_count)
  );

  assign dst_mac  = req_dout[MAC_W-1:0];
  assign src_mac  = req_dout[2*MAC_W-1:MAC_W];
  assign src_port = req_dout[REQ_W-1 -: NUM_IQ_BITS];

  // Lookup handshake: result space is reserved in IDLE, so the WAIT_ACK write always fits.
  always_comb begin
    l_state_next = l_state_reg;
    req_pop      = 1'b0;
    res_push     = 1'b0;
    case (l_state_reg)
      IDLE: begin
        if (!req_empty && !res_full) l_state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (lookup_ack) begin
          res_push     = 1'b1;
          req_pop      = 1'b1;
          l_state_next = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!lookup_ack) l_state_next = IDLE;
      end
      default: l_state_next = IDLE;
    endcase
  end

  // Lookup state register; reset abandons any lookup in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) l_state_reg <= IDLE;
    else          l_state_reg <= l_state_next;
  end

  assign lookup_req = (l_state_reg == WAIT_ACK);

  small_fifo_fwft #(
    .WIDTH      (NUM_OUTPUT_QUEUES),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_res_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (lut_dst_ports),
    .wr_en   (res_push),
    .rd_en   (res_rd_en),
    .dout    (res_dst_ports),
    .full    (res_full),
    .empty   (res_empty),
    .count   (res_count_unused)
  );

endmodule

// File: tb/tb_mac_lookup_req_gen.sv
// Directed bench: a LUT responder checks each request against the queued
// expectation, and results are popped and compared in order.
module tb_mac_lookup_req_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [2:0]  src_port;
  logic        lookup_req;
  logic        lookup_ack;
  logic [7:0]  lut_dst_ports;
  logic [7:0]  res_dst_ports;
  logic        res_empty;
  logic        res_rd_en;
  logic        parse_err;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [2:0]  port;
    logic [7:0]  ports;
  } req_t;

  req_t       exp_req_q[$];
  logic [7:0] res_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         lut_delay  = 3;
  int         lut_hold   = 1;

  always #5 clk = ~clk;

  mac_lookup_req_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .in_wr         (in_wr),
    .in_rdy        (in_rdy),
    .dst_mac       (dst_mac),
    .src_mac       (src_mac),
    .src_port      (src_port),
    .lookup_req    (lookup_req),
    .lookup_ack    (lookup_ack),
    .lut_dst_ports (lut_dst_ports),
    .res_dst_ports (res_dst_ports),
    .res_empty     (res_empty),
    .res_rd_en     (res_rd_en),
    .parse_err     (parse_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [63:0] d);
    in_ctrl = c;
    in_data = d;
    in_wr   = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic has_hdr, input logic [2:0] port,
                          input logic [47:0] dst, input logic [47:0] src,
                          input logic [7:0] ports);
    req_t r;
    if (has_hdr) drive(8'hFF, {45'h0, port, 16'h1234});
    drive(8'h00, {dst, src[47:32]});
    r.dst   = dst;
    r.src   = src;
    r.port  = has_hdr ? port : 3'd0;
    r.ports = ports;
    exp_req_q.push_back(r);
    drive(8'h00, {src[31:0], 32'hDEAD_BEEF});
    drive(8'h80, 64'h0);
    in_wr = 1'b0;
  endtask

  task automatic send_runt();
    drive(8'hFF, {45'h0, 3'd5, 16'h0});
    drive(8'h00, 64'h0102_0304_0506_0708);
    drive(8'h0F, 64'h1111_2222_3333_4444);
    in_wr = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int         cnt = 0;
    logic [7:0] e;
    while (res_empty && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (res_q.size() > 0) e = res_q.pop_front();
    else                  e = 8'hxx;
    chk(tag, {56'h0, res_dst_ports}, {56'h0, e});
    res_rd_en = 1'b1;
    @(negedge clk);
    res_rd_en = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int cnt = 0;
    while (!lookup_ack && cnt < 100) begin
      @(posedge clk);
      cnt++;
    end
    chk(tag, {63'h0, lookup_ack}, 64'h1);
  endtask

  task automatic wait_req(input string tag);
    int cnt = 0;
    while (!lookup_req && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, {63'h0, lookup_req}, 64'h1);
  endtask

  task automatic wait_rdy();
    int cnt = 0;
    while (!in_rdy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("in_rdy_wait", {63'h0, in_rdy}, 64'h1);
  endtask

  // LUT model: checks request fields, acks after lut_delay, holds ack lut_hold cycles.
  initial begin : lut_model
    req_t cur;
    int   cnt;
    lookup_ack    = 1'b0;
    lut_dst_ports = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n && lookup_req) begin
        if (exp_req_q.size() > 0) begin
          cur = exp_req_q.pop_front();
        end else begin
          cur.dst = 'x; cur.src = 'x; cur.port = 'x; cur.ports = 8'h00;
        end
        chk("req_dst_mac", {16'h0, dst_mac}, {16'h0, cur.dst});
        chk("req_src_mac", {16'h0, src_mac}, {16'h0, cur.src});
        chk("req_src_port", {61'h0, src_port}, {61'h0, cur.port});
        cnt = 0;
        while (cnt < lut_delay && reset_n) begin
          @(negedge clk);
          cnt++;
          if (reset_n) chk("req_held", {63'h0, lookup_req}, 64'h1);
        end
        if (reset_n) begin
          lookup_ack    = 1'b1;
          lut_dst_ports = cur.ports;
          res_q.push_back(cur.ports);
          for (int h = 0; h < lut_hold; h++) begin
            @(negedge clk);
            chk("req_low_during_ack", {63'h0, lookup_req}, 64'h0);
          end
          lookup_ack    = 1'b0;
          lut_dst_ports = 8'h00;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset_n   = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    in_wr     = 1'b0;
    res_rd_en = 1'b0;
    #1;
    chk("rst_lookup_req", {63'h0, lookup_req}, 64'h0);
    chk("rst_parse_err", {63'h0, parse_err}, 64'h0);
    chk("rst_in_rdy", {63'h0, in_rdy}, 64'h1);
    chk("rst_res_empty", {63'h0, res_empty}, 64'h1);
    chk("rst_dst_mac", {16'h0, dst_mac}, 64'h0);
    chk("rst_res_dst_ports", {56'h0, res_dst_ports}, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single packet, ack 3 cycles after the request.
    lut_delay = 3; lut_hold = 1;
    send_pkt(1'b1, 3'd2, 48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 8'h04);
    wait_ack("single_ack_seen");
    @(negedge clk);
    chk("single_res_empty", {63'h0, res_empty}, 64'h0);
    chk("single_res_ports", {56'h0, res_dst_ports}, 64'h04);
    pop_check("single_pop");
    chk("single_drained", {63'h0, res_empty}, 64'h1);

    // Handshake: ack held 5 cycles yields exactly one result.
    lut_delay = 2; lut_hold = 5;
    send_pkt(1'b1, 3'd7, 48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 8'hA5);
    wait_ack("hs_ack_seen");
    repeat (8) @(negedge clk);
    chk("hs_no_rereq", {63'h0, lookup_req}, 64'h0);
    pop_check("hs_pop");
    chk("hs_one_result", {63'h0, res_empty}, 64'h1);

    // Back-to-back minimal packets; in_rdy drops with 3 requests queued.
    lut_delay = 6; lut_hold = 1;
    send_pkt(1'b0, 3'd0, 48'h1111_1111_1111, 48'h2222_2222_2222, 8'h01);
    send_pkt(1'b0, 3'd0, 48'h3333_3333_3333, 48'h4444_4444_4444, 8'h02);
    chk("b2b_rdy_at2", {63'h0, in_rdy}, 64'h1);
    send_pkt(1'b0, 3'd0, 48'h5555_5555_5555, 48'h6666_6666_6666, 8'h40);
    chk("b2b_rdy_at3", {63'h0, in_rdy}, 64'h0);
    send_pkt(1'b0, 3'd0, 48'h7777_7777_7777, 48'h8888_8888_8888, 8'h80);
    for (int i = 0; i < 4; i++) pop_check("b2b_pop");
    repeat (5) @(negedge clk);

    // Result FIFO full: fifth lookup waits for a pop.
    lut_delay = 2; lut_hold = 1;
    for (int i = 0; i < 5; i++) begin
      wait_rdy();
      send_pkt(1'b1, 3'(i + 1), {8'hC0, 40'(i)}, {8'hD0, 40'(i * 3)}, 8'(8'h10 + i));
    end
    repeat (40) @(negedge clk);
    chk("full_res_not_empty", {63'h0, res_empty}, 64'h0);
    chk("full_head_is_5th", {16'h0, dst_mac}, {16'h0, 8'hC0, 40'd4});
    for (int i = 0; i < 5; i++) begin
      chk("full_no_req", {63'h0, lookup_req}, 64'h0);
      @(negedge clk);
    end
    pop_check("full_pop_first");
    wait_req("full_req_after_pop");
    for (int i = 0; i < 4; i++) pop_check("full_pop_rest");
    repeat (5) @(negedge clk);

    // Runt packet, then a good packet without IOQ header.
    send_runt();
    chk("runt_parse_err", {63'h0, parse_err}, 64'h1);
    @(negedge clk);
    chk("runt_parse_err_pulse", {63'h0, parse_err}, 64'h0);
    repeat (4) @(negedge clk);
    chk("runt_no_req", {63'h0, lookup_req}, 64'h0);
    chk("runt_req_fifo_empty", {16'h0, dst_mac}, 64'h0);
    send_pkt(1'b0, 3'd0, 48'hFEED_FACE_0001, 48'hBEEF_CAFE_0002, 8'h3F);
    pop_check("after_runt_pop");

    // Reset while a lookup waits for ack.
    lut_delay = 20; lut_hold = 1;
    send_pkt(1'b1, 3'd4, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 8'h3C);
    wait_req("rst_mid_req_seen");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_lookup_req", {63'h0, lookup_req}, 64'h0);
    chk("rst_mid_res_empty", {63'h0, res_empty}, 64'h1);
    chk("rst_mid_in_rdy", {63'h0, in_rdy}, 64'h1);
    chk("rst_mid_dst_mac", {16'h0, dst_mac}, 64'h0);
    exp_req_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    lut_delay = 2;
    @(negedge clk);
    send_pkt(1'b1, 3'd6, 48'h5A5A_5A5A_5A5A, 48'hA5A5_A5A5_A5A5, 8'h99);
    pop_check("rst_after_pop");
    repeat (6) @(negedge clk);
    chk("rst_after_one_result", {63'h0, res_empty}, 64'h1);
    chk("all_requests_seen", 64'(exp_req_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
